load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/load_formatter.sv | 30 +++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DEFAULT_TIMEOUT = 255;
  localparam int unsigned CNT_W           = 8;

  // Size/sign legality plus natural alignment for one access.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects and extends the addressed byte/half of a read word.
module load_formatter
  import lsu_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] word,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  output logic [width-1:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = word[{offset, 3'b000} +: 8];
    sel_h = offset[1] ? word[31:16] : word[15:0];
    data  = '0;
    case (funct3)
      F3_B:    data = {{(width-8){sel_b[7]}}, sel_b};
      F3_H:    data = {{(width-16){sel_h[15]}}, sel_h};
      F3_W:    data = word;
      F3_BU:   data = {{(width-8){1'b0}}, sel_b};
      F3_HU:   data = {{(width-16){1'b0}}, sel_h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding memory access with stall, fault and timeout handling.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned width   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       Funct3,
  input  logic [width-1:0] ALUResult,
  input  logic [width-1:0] WriteData,
  output logic [width-1:0] ReadData,
  output logic             Stall,
  output logic             Misaligned,
  output logic             BusError,
  output logic             MemReq,
  output logic             MemWE,
  output logic [width-1:0] MemAddr,
  output logic [width-1:0] MemWData,
  output logic [3:0]       MemBE,
  input  logic             MemReady,
  input  logic [width-1:0] MemRData
);

  lsu_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;

  logic             req;
  logic             legal;
  logic [3:0]       lane_be;
  logic [width-1:0] lane_data;
  logic [width-1:0] fmt_data;

  assign req   = MemRead | MemWrite;
  assign legal = access_ok(MemWrite, Funct3, ALUResult[1:0]);

  // Request-cycle handshake is combinational; reset masks it so every output reads 0.
  assign Stall      = reset_n & ((state == ST_BUSY) | ((state == ST_IDLE) & req & legal));
  assign Misaligned = reset_n & (state == ST_IDLE) & req & ~legal;

  // Byte-lane steering for the request; loads use the same enables.
  always_comb begin
    lane_be   = 4'b1111;
    lane_data = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        lane_be   = 4'b0001 << ALUResult[1:0];
        lane_data = width'({4{WriteData[7:0]}});
      end
      2'b01: begin
        lane_be   = ALUResult[1] ? 4'b1100 : 4'b0011;
        lane_data = width'({2{WriteData[15:0]}});
      end
      default: begin
        lane_be   = 4'b1111;
        lane_data = WriteData;
      end
    endcase
  end

  load_formatter #(.width(width)) u_fmt (
    .word   (MemRData),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (fmt_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      MemReq   <= 1'b0;
      MemWE    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      MemBE    <= '0;
      ReadData <= '0;
      BusError <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ReadData <= '0;
          BusError <= 1'b0;
          if (req && legal) begin
            state    <= ST_BUSY;
            wait_cnt <= '0;
            off_q    <= ALUResult[1:0];
            f3_q     <= Funct3;
            MemReq   <= 1'b1;
            MemWE    <= MemWrite;
            MemAddr  <= {ALUResult[width-1:2], 2'b00};
            MemWData <= MemWrite ? lane_data : '0;
            MemBE    <= lane_be;
          end
        end
        ST_BUSY: begin
          // A response on the final allowed cycle still wins over the timeout.
          if (MemReady || (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
            state    <= ST_DONE;
            MemReq   <= 1'b0;
            MemWE    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemBE    <= '0;
            BusError <= ~MemReady;
            ReadData <= (MemReady && !MemWE) ? fmt_data : '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          ReadData <= '0;
          BusError <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a behavioural access model.
module tb_load_store_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          MemRead, MemWrite, MemReady;
  logic [2:0]    Funct3;
  logic [W-1:0]  ALUResult, WriteData, ReadData, MemAddr, MemWData, MemRData;
  logic          Stall, Misaligned, BusError, MemReq, MemWE;
  logic [3:0]    MemBE;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_rdata, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_berr;
  int          obs_stall_cycles, obs_req_cycles;

  always #5 clk = ~clk;

  load_store_unit #(.width(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Misaligned(Misaligned),
    .BusError(BusError), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemBE(MemBE), .MemReady(MemReady), .MemRData(MemRData)
  );

  // ---------------- reference model ----------------
  function automatic bit m_legal(bit wr, bit [2:0] f3, bit [31:0] addr);
    int unsigned size;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
    if (wr && f3 >= 4) return 1'b0;
    size = 1 << (f3 % 4);
    return (addr % size) == 0;
  endfunction

  function automatic bit [3:0] m_be(bit [2:0] f3, bit [31:0] addr);
    int unsigned n;
    n = 1 << (f3 % 4);
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic bit [31:0] m_wdata(bit [2:0] f3, bit [31:0] wd);
    int unsigned n;
    bit [31:0] r;
    n = 1 << (f3 % 4);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic bit [31:0] m_load(bit [2:0] f3, bit [31:0] word, bit [31:0] addr);
    bit [31:0] s, v;
    s = word >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = s & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = s & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd2: v = word;
      3'd4: v = s & 32'hFF;
      3'd5: v = s & 32'hFFFF;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // One access, entered #1 after a rising edge with the DUT idle; returns #1 after the
  // edge following DONE, so consecutive calls issue back-to-back requests.
  task automatic access(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, input bit [31:0] mword, input int delay,
                        input string tag);
    bit        req, ok, berr;
    bit [31:0] exp_rd;
    req    = rd | wr;
    ok     = req && m_legal(wr, f3, addr);
    berr   = (delay >= int'(TO));
    exp_rd = (berr || wr) ? 32'h0 : m_load(f3, mword, addr);
    obs_stall_cycles = 0;
    obs_req_cycles   = 0;
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
    MemReady = 1'b0;
    #1;
    checks++;
    if ({Stall, Misaligned, MemReq} !== {ok, req && !ok, 1'b0}) begin
      errors++;
      $display("FAIL %s request: stall/mis/req=%b expected %b", tag,
               {Stall, Misaligned, MemReq}, {ok, req && !ok, 1'b0});
    end
    if (Stall) obs_stall_cycles++;
    @(posedge clk); #1;
    if (!ok) begin
      MemRead = 1'b0; MemWrite = 1'b0;
      checks++;
      if ({MemReq, Stall, BusError, ReadData} !== 35'h0) begin
        errors++;
        $display("FAIL %s no-access: req/stall/berr/rdata=%b/%b/%b/%h expected all 0", tag,
                 MemReq, Stall, BusError, ReadData);
      end
      return;
    end
    // core inputs are don't-care while the access is outstanding
    MemRead = 1'($urandom); MemWrite = 1'($urandom); Funct3 = 3'($urandom);
    ALUResult = $urandom; WriteData = $urandom;
    for (int k = 0; k < int'(TO); k++) begin
      checks++;
      if ({MemReq, MemWE, MemBE, MemAddr, Stall, Misaligned, ReadData} !==
          {1'b1, wr, m_be(f3, addr), addr & ~32'd3, 1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL %s busy%0d: req=%b we=%b be=%b addr=%h stall=%b mis=%b rd=%h expected we=%b be=%b addr=%h",
                 tag, k, MemReq, MemWE, MemBE, MemAddr, Stall, Misaligned, ReadData,
                 wr, m_be(f3, addr), addr & ~32'd3);
      end
      if (wr) begin
        checks++;
        if (MemWData !== m_wdata(f3, wd)) begin
          errors++;
          $display("FAIL %s wdata: got %h expected %h", tag, MemWData, m_wdata(f3, wd));
        end
      end
      obs_be = MemBE; obs_wdata = MemWData;
      if (MemReq) obs_req_cycles++;
      if (Stall) obs_stall_cycles++;
      if (k == delay) begin MemReady = 1'b1; MemRData = mword; end
      else begin MemReady = 1'b0; MemRData = $urandom; end
      @(posedge clk); #1;
      MemReady = 1'b0; MemRData = $urandom;
      if (k == delay) break;
    end
    checks++;
    if ({MemReq, MemBE, Stall, BusError, ReadData} !== {1'b0, 4'b0, 1'b0, berr, exp_rd}) begin
      errors++;
      $display("FAIL %s done: req=%b be=%b stall=%b berr=%b rd=%h expected berr=%b rd=%h",
               tag, MemReq, MemBE, Stall, BusError, ReadData, berr, exp_rd);
    end
    if (Stall) obs_stall_cycles++;
    obs_rdata = ReadData; obs_berr = BusError;
    @(posedge clk); #1;
    checks++;
    if ({MemReq, BusError, ReadData, MemBE} !== 38'h0) begin
      errors++;
      $display("FAIL %s after-done: req=%b berr=%b rd=%h be=%b expected all 0", tag,
               MemReq, BusError, ReadData, MemBE);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUResult = 32'h100;
    WriteData = 32'h0; MemReady = 1'b0; MemRData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ReadData, Stall, Misaligned, BusError, MemReq, MemWE, MemAddr, MemWData, MemBE} !== 104'h0) begin
      errors++;
      $display("FAIL reset: rd=%h stall=%b mis=%b berr=%b req=%b we=%b addr=%h wd=%h be=%b expected all 0",
               ReadData, Stall, Misaligned, BusError, MemReq, MemWE, MemAddr, MemWData, MemBE);
    end
    reset_n = 1'b1;
    access(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 0, "first_after_reset");
  endtask

  task automatic test_lw();
    access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
    checks++;
    if ({obs_rdata, 8'(obs_stall_cycles), 8'(obs_req_cycles)} !== {32'hDEADBEEF, 8'd2, 8'd1}) begin
      errors++;
      $display("FAIL lw_const: rd=%h stall_cycles=%0d req_cycles=%0d expected DEADBEEF/2/1",
               obs_rdata, obs_stall_cycles, obs_req_cycles);
    end
  endtask

  task automatic test_lb_lbu();
    access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 1, "lb");
    checks++;
    if (obs_rdata !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_const: got %h expected FFFFFF80", obs_rdata);
    end
    access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 2, "lbu");
    checks++;
    if (obs_rdata !== 32'h00000080) begin
      errors++; $display("FAIL lbu_const: got %h expected 00000080", obs_rdata);
    end
  endtask

  task automatic test_sh();
    access(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 0, "sh");
    checks++;
    if ({obs_be, obs_wdata} !== {4'b1100, 32'hABCDABCD}) begin
      errors++;
      $display("FAIL sh_const: be=%b wd=%h expected 1100/ABCDABCD", obs_be, obs_wdata);
    end
    // both strobes high is a store
    access(1'b1, 1'b1, 3'd0, 32'h301, 32'h000000A5, 32'h0, 1, "rw_as_store");
    checks++;
    if ({obs_be, obs_wdata} !== {4'b0010, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL rw_const: be=%b wd=%h expected 0010/A5A5A5A5", obs_be, obs_wdata);
    end
  endtask

  task automatic test_misaligned();
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUResult = 32'h101;
    #1;
    checks++;
    if ({Misaligned, Stall, ReadData} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL lw_misaligned: mis=%b stall=%b rd=%h expected 1/0/0", Misaligned, Stall, ReadData);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (MemReq !== 1'b0) begin
        errors++; $display("FAIL lw_misaligned_req%0d: got %b expected 0", i, MemReq);
      end
    end
    MemRead = 1'b0;
    access(1'b0, 1'b1, 3'd4, 32'h200, 32'h0, 32'h0, 0, "sbu_illegal");
    access(1'b1, 1'b0, 3'd5, 32'h203, 32'h0, 32'h0, 0, "lhu_misaligned");
  endtask

  task automatic test_timeout();
    access(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h12345678, int'(TO) + 2, "timeout");
    checks++;
    if ({8'(obs_req_cycles), obs_berr, obs_rdata} !== {8'(TO), 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL timeout_const: req_cycles=%0d berr=%b rd=%h expected %0d/1/0",
               obs_req_cycles, obs_berr, obs_rdata, TO);
    end
    access(1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFE0001, int'(TO) - 1, "last_cycle_ready");
  endtask

  task automatic test_reset_mid_busy();
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUResult = 32'h500;
    @(posedge clk); #1;
    checks++;
    if (MemReq !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: req=%b expected 1", MemReq);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({MemReq, Stall, MemBE} !== 6'h0) begin
      errors++;
      $display("FAIL mid_reset: req=%b stall=%b be=%b expected all 0", MemReq, Stall, MemBE);
    end
    MemRead = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    access(1'b0, 1'b1, 3'd2, 32'h600, 32'h55AA33CC, 32'h0, 1, "sw_after_reset");
    checks++;
    if ({obs_be, obs_wdata} !== {4'b1111, 32'h55AA33CC}) begin
      errors++;
      $display("FAIL sw_after_reset_const: be=%b wd=%h expected 1111/55AA33CC", obs_be, obs_wdata);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b0, 3'd1, 32'h702, 32'h0, 32'h8001_7FFF, 0, "b2b_lh");
    access(1'b0, 1'b1, 3'd0, 32'h703, 32'h0000_00EE, 32'h0, 0, "b2b_sb");
    access(1'b1, 1'b0, 3'd5, 32'h700, 32'h0, 32'h1234_F00F, 0, "b2b_lhu");
    access(1'b1, 1'b0, 3'd0, 32'h701, 32'h0, 32'h0000_9900, 0, "b2b_lb");
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      bit [31:0] addr;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'd3 | 32'($urandom_range(0, 1) * 2);
      access(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
             $urandom_range(0, 5), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
